// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding.
// Holds one decoded instruction and selects ALU operands from the register file, EX/MEM or MEM/WB.
module id_ex_forward_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] id_read_data_1,
    input  logic [31:0] id_read_data_2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [3:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic [3:0]  id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_write_reg,
    input  logic [31:0] exmem_alu_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_write_reg,
    input  logic [31:0] memwb_write_data,
    output logic [31:0] ex_alu_a,
    output logic [31:0] ex_alu_b,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_alu_op,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_write_reg,
    output logic [4:0]  ex_rt,
    output logic [3:0]  ex_ctrl,
    output logic        ex_valid,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel
);

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ctrl;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
        logic [4:0]  shamt;
    } ex_stage_t;

    ex_stage_t ex_q, ex_d;
    fwd_sel_e  a_sel, b_sel;
    logic [31:0] fwd_rs, fwd_rt;

    // Flush wins over stall; a bubble is an all-zero stage.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (!stall) begin
            ex_d.valid     = 1'b1;
            ex_d.ctrl      = id_ctrl;
            ex_d.alu_op    = id_alu_op;
            ex_d.alu_src   = id_alu_src;
            ex_d.rd1       = id_read_data_1;
            ex_d.rd2       = id_read_data_2;
            ex_d.imm       = id_imm;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.write_reg = id_reg_dst ? id_rd : id_rt;
            ex_d.shamt     = id_shamt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    function automatic fwd_sel_e fwd_pick(input logic [4:0] idx);
        if (!ex_q.valid || idx == 5'd0) begin
            return FWD_RF;
        end else if (exmem_reg_write && exmem_write_reg == idx) begin
            return FWD_EXMEM;
        end else if (memwb_reg_write && memwb_write_reg == idx) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

    always_comb begin
        a_sel = fwd_pick(ex_q.rs);
        b_sel = fwd_pick(ex_q.rt);

        fwd_rs = ex_q.rd1;
        case (a_sel)
            FWD_EXMEM: fwd_rs = exmem_alu_result;
            FWD_MEMWB: fwd_rs = memwb_write_data;
            default:   fwd_rs = ex_q.rd1;
        endcase

        fwd_rt = ex_q.rd2;
        case (b_sel)
            FWD_EXMEM: fwd_rt = exmem_alu_result;
            FWD_MEMWB: fwd_rt = memwb_write_data;
            default:   fwd_rt = ex_q.rd2;
        endcase
    end

    // Store data always carries the forwarded rt, independent of the B-operand mux.
    assign ex_alu_a      = fwd_rs;
    assign ex_alu_b      = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_shamt      = ex_q.shamt;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_write_reg  = ex_q.write_reg;
    assign ex_rt         = ex_q.rt;
    assign ex_ctrl       = ex_q.ctrl;
    assign ex_valid      = ex_q.valid;
    assign fwd_a_sel     = a_sel;
    assign fwd_b_sel     = b_sel;

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Self-checking bench for id_ex_forward_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the ID/EX stage and its forwarding rules.
module tb_id_ex_forward_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush;
    logic [31:0] id_read_data_1, id_read_data_2, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [3:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst;
    logic [3:0]  id_ctrl;
    logic        exmem_reg_write;
    logic [4:0]  exmem_write_reg;
    logic [31:0] exmem_alu_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_write_reg;
    logic [31:0] memwb_write_data;
    logic [31:0] ex_alu_a, ex_alu_b, ex_store_data;
    logic [4:0]  ex_shamt, ex_write_reg, ex_rt;
    logic [3:0]  ex_alu_op, ex_ctrl;
    logic        ex_valid;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int checks   = 0;
    int failures = 0;

    // Model of the instruction currently held in EX
    logic        m_valid, m_alu_src;
    logic [3:0]  m_ctrl, m_alu_op;
    logic [31:0] m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs, m_rt, m_wreg, m_shamt;

    id_ex_forward_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .id_read_data_1(id_read_data_1), .id_read_data_2(id_read_data_2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_write_reg(exmem_write_reg),
        .exmem_alu_result(exmem_alu_result),
        .memwb_reg_write(memwb_reg_write), .memwb_write_reg(memwb_write_reg),
        .memwb_write_data(memwb_write_data),
        .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_shamt(ex_shamt), .ex_alu_op(ex_alu_op),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_rt(ex_rt),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_alu_src = 0; m_ctrl = 0; m_alu_op = 0;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs = 0; m_rt = 0; m_wreg = 0; m_shamt = 0;
    endtask

    task automatic model_edge();
        if (!reset || flush) begin
            model_clear();
        end else if (!stall) begin
            m_valid = 1; m_alu_src = id_alu_src; m_ctrl = id_ctrl; m_alu_op = id_alu_op;
            m_rd1 = id_read_data_1; m_rd2 = id_read_data_2; m_imm = id_imm;
            m_rs = id_rs; m_rt = id_rt; m_shamt = id_shamt;
            m_wreg = id_reg_dst ? id_rd : id_rt;
        end
    endtask

    task automatic ref_fwd(input logic [4:0] idx, input logic [31:0] rf_val,
                           output logic [31:0] val, output logic [1:0] sel);
        val = rf_val; sel = 2'b00;
        if (m_valid && idx != 0) begin
            if (exmem_reg_write && exmem_write_reg == idx) begin
                val = exmem_alu_result; sel = 2'b10;
            end else if (memwb_reg_write && memwb_write_reg == idx) begin
                val = memwb_write_data; sel = 2'b01;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] ea, ert;
        logic [1:0]  sa, sb;
        ref_fwd(m_rs, m_rd1, ea, sa);
        ref_fwd(m_rt, m_rd2, ert, sb);
        check({tag, ":alu_a"},      ex_alu_a, ea);
        check({tag, ":alu_b"},      ex_alu_b, m_alu_src ? m_imm : ert);
        check({tag, ":store_data"}, ex_store_data, ert);
        check({tag, ":fwd_a_sel"},  {30'd0, fwd_a_sel}, {30'd0, sa});
        check({tag, ":fwd_b_sel"},  {30'd0, fwd_b_sel}, {30'd0, sb});
        check({tag, ":shamt"},      {27'd0, ex_shamt}, {27'd0, m_shamt});
        check({tag, ":alu_op"},     {28'd0, ex_alu_op}, {28'd0, m_alu_op});
        check({tag, ":write_reg"},  {27'd0, ex_write_reg}, {27'd0, m_wreg});
        check({tag, ":rt"},         {27'd0, ex_rt}, {27'd0, m_rt});
        check({tag, ":ctrl"},       {28'd0, ex_ctrl}, {28'd0, m_ctrl});
        check({tag, ":valid"},      {31'd0, ex_valid}, {31'd0, m_valid});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_id();
        id_read_data_1 = $urandom; id_read_data_2 = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom); id_shamt = 5'($urandom);
        id_alu_op = 4'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
        id_ctrl = 4'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_reg_write = 1'($urandom); exmem_write_reg = 5'($urandom_range(0, 7));
        exmem_alu_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_write_reg = 5'($urandom_range(0, 7));
        memwb_write_data = $urandom;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_write_reg = 0; exmem_alu_result = 0;
        memwb_reg_write = 0; memwb_write_reg = 0; memwb_write_data = 0;
    endtask

    task automatic set_id(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [3:0] op, input logic alu_src, input logic [3:0] ctrl);
        id_read_data_1 = rd1; id_read_data_2 = rd2; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_shamt = 5'd4;
        id_alu_op = op; id_alu_src = alu_src; id_reg_dst = 1'b1; id_ctrl = ctrl;
    endtask

    initial begin
        reset = 0; stall = 0; flush = 0;
        model_clear();
        rand_id(); rand_fwd();
        #2;
        check_all("reset_async");
        tick();
        check_all("reset_held");
        check("reset_held_alu_a", ex_alu_a, 32'd0);

        // Release reset between edges, then capture rd1=0x11
        no_fwd();
        set_id(32'h11, 32'h22, 32'h0, 5'd1, 5'd2, 5'd3, 4'd2, 1'b0, 4'b1000);
        reset = 1;
        tick();
        check("first_capture_alu_a", ex_alu_a, 32'h11);
        check_all("first_capture");

        // EX/MEM forwarding of rs
        set_id(32'h1, 32'h2, 32'h0, 5'd5, 5'd6, 5'd8, 4'd2, 1'b0, 4'b1000);
        tick();
        exmem_reg_write = 1; exmem_write_reg = 5'd5; exmem_alu_result = 32'hAAAA;
        #1;
        check("exmem_fwd_alu_a", ex_alu_a, 32'hAAAA);
        check("exmem_fwd_sel", {30'd0, fwd_a_sel}, 32'd2);
        check_all("exmem_fwd");

        // EX/MEM beats MEM/WB for the same rt
        no_fwd();
        set_id(32'h1, 32'h2, 32'h0, 5'd9, 5'd7, 5'd8, 4'd2, 1'b0, 4'b1000);
        tick();
        exmem_reg_write = 1; exmem_write_reg = 5'd7; exmem_alu_result = 32'h22;
        memwb_reg_write = 1; memwb_write_reg = 5'd7; memwb_write_data = 32'h33;
        #1;
        check("prio_alu_b", ex_alu_b, 32'h22);
        check("prio_store", ex_store_data, 32'h22);
        check("prio_sel", {30'd0, fwd_b_sel}, 32'd2);
        check_all("prio");

        // Register 0 is never forwarded
        no_fwd();
        set_id(32'h1234, 32'h2, 32'h0, 5'd0, 5'd6, 5'd8, 4'd2, 1'b0, 4'b1000);
        tick();
        exmem_reg_write = 1; exmem_write_reg = 5'd0; exmem_alu_result = 32'hFFFF;
        #1;
        check("zero_reg_alu_a", ex_alu_a, 32'h1234);
        check("zero_reg_sel", {30'd0, fwd_a_sel}, 32'd0);
        check_all("zero_reg");

        // Stall holds for two cycles, then flush (with stall) inserts a bubble
        no_fwd();
        set_id(32'h100, 32'h200, 32'h300, 5'd3, 5'd4, 5'd6, 4'b0011, 1'b0, 4'b1010);
        tick();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            rand_id();
            tick();
            check("stall_alu_op", {28'd0, ex_alu_op}, 32'h3);
            check("stall_alu_a", ex_alu_a, 32'h100);
            check("stall_write_reg", {27'd0, ex_write_reg}, 32'd6);
            check_all("stall");
        end
        flush = 1;
        tick();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_ctrl", {28'd0, ex_ctrl}, 32'd0);
        check("flush_alu_op", {28'd0, ex_alu_op}, 32'd0);
        check_all("flush");
        rand_fwd();
        #1;
        check_all("flush_no_fwd");
        stall = 0; flush = 0; no_fwd();

        // Immediate path: B takes imm, store data still forwarded from MEM/WB
        set_id(32'h1, 32'h2, 32'hFFFF_FFF0, 5'd3, 5'd9, 5'd8, 4'd2, 1'b1, 4'b1100);
        tick();
        memwb_reg_write = 1; memwb_write_reg = 5'd9; memwb_write_data = 32'h55;
        #1;
        check("imm_alu_b", ex_alu_b, 32'hFFFF_FFF0);
        check("imm_store", ex_store_data, 32'h55);
        check("imm_sel", {30'd0, fwd_b_sel}, 32'd1);
        check_all("imm");

        // Reset during stall+flush wins immediately; capture resumes after release
        stall = 1; flush = 1;
        #2;
        reset = 0;
        model_clear();
        #1;
        check_all("reset_mid_flush");
        tick();
        check_all("reset_mid_flush_edge");
        stall = 0; flush = 0;
        set_id(32'h77, 32'h88, 32'h0, 5'd1, 5'd2, 5'd3, 4'd5, 1'b0, 4'b0001);
        #2;
        reset = 1;
        tick();
        check("post_reset_alu_a", ex_alu_a, 32'h77);
        check_all("post_reset");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            rand_id();
            rand_fwd();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            check_all("rand_edge");
            rand_fwd();
            #1;
            check_all("rand_comb");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_forward_stage.md
ID_EX_FORWARD_STAGE -- requirements
Module: id_ex_forward_stage

Interface
REQ-001 Parameter: none; all widths fixed (32-bit datapath, 5-bit register indices, 4-bit ALUOperation).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately when low.
REQ-004 stall  in  1  hold current EX contents (no capture).
REQ-005 flush  in  1  load bubble into EX on next edge; overrides stall.
REQ-006 id_read_data_1 / id_read_data_2  in  32 each  register-file operands for rs / rt.
REQ-007 id_imm  in  32  sign- or zero-extended immediate.
REQ-008 id_rs / id_rt / id_rd / id_shamt  in  5 each  instruction fields.
REQ-009 id_alu_op  in  4  ALUOperation code; id_alu_src  in  1  1 = B takes immediate; id_reg_dst  in  1  1 = write rd, 0 = write rt.
REQ-010 id_ctrl  in  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-011 exmem_reg_write  in  1, exmem_write_reg  in  5, exmem_alu_result  in  32  EX/MEM forwarding source.
REQ-012 memwb_reg_write  in  1, memwb_write_reg  in  5, memwb_write_data  in  32  MEM/WB forwarding source.
REQ-013 ex_alu_a / ex_alu_b  out  32 each  ALU A/B operands; ex_shamt  out  5; ex_alu_op  out  4.
REQ-014 ex_store_data  out  32  forwarded rt value for stores; ex_write_reg  out  5; ex_rt  out  5 (for load-use detection).
REQ-015 ex_ctrl  out  4  registered id_ctrl; ex_valid  out  1  1 = real instruction in EX.
REQ-016 fwd_a_sel / fwd_b_sel  out  2 each  00 = register file, 10 = EX/MEM, 01 = MEM/WB.

Function
REQ-017 Capture: on rising clk, flush=0 and stall=0 -> all id_* fields registered, ex_valid<=1; latency exactly one cycle.
REQ-018 Write register selected at capture: id_reg_dst ? id_rd : id_rt; only the selected 5-bit index is stored.
REQ-019 Stall: flush=0, stall=1 -> every register holds its value; forwarding continues to be re-evaluated each cycle.
REQ-020 Flush: flush=1 (any stall) -> ex_valid<=0, ex_ctrl<=0, ex_alu_op<=0, all data/index registers <=0.
REQ-021 Forward A (combinational from registered rs): exmem_reg_write=1 and exmem_write_reg!=0 and ==rs -> exmem_alu_result, sel 10; else memwb_reg_write=1 and memwb_write_reg!=0 and ==rs -> memwb_write_data, sel 01; else registered rd1, sel 00.
REQ-022 Forward B: same rule applied to registered rt, yields fwd_rt.
REQ-023 EX/MEM match always wins over MEM/WB match for the same register.
REQ-024 Register index 0 never forwarded; sel 00 whenever rs/rt = 0.
REQ-025 ex_store_data = fwd_rt regardless of alu_src; ex_alu_b = alu_src ? registered imm : fwd_rt.
REQ-026 fwd_b_sel reflects the rt forwarding decision even when alu_src=1.
REQ-027 Forwarding applies only while ex_valid=1; ex_valid=0 -> both sel 00.
REQ-028 No arithmetic performed; all paths are pure 32-bit selection, no truncation or extension.

Reset
REQ-029 reset low -> asynchronously: ex_valid=0, ex_ctrl=0, ex_alu_op=0, all registered data/index fields=0, hence ex_alu_a=ex_alu_b=ex_store_data=0, sel=00.
REQ-030 Reset asserted mid-stall or mid-flush -> reset state wins immediately; first capture on first rising edge after reset high with stall=0.

Verification
REQ-031 Reset: reset=0 with arbitrary inputs -> all outputs 0, ex_valid=0; release, next edge captures id_read_data_1=0x11 -> ex_alu_a=0x11.
REQ-032 EX/MEM forward: capture rs=5, rd1=0x1; exmem_reg_write=1, exmem_write_reg=5, result=0xAAAA -> ex_alu_a=0xAAAA, fwd_a_sel=10.
REQ-033 Priority: rt=7, exmem and memwb both write reg 7 (0x22, 0x33), alu_src=0 -> ex_alu_b=0x22, ex_store_data=0x22, fwd_b_sel=10.
REQ-034 Zero register: rs=0, exmem_write_reg=0 with reg_write=1, result=0xFFFF -> ex_alu_a=registered rd1, fwd_a_sel=00.
REQ-035 Stall then flush: capture op=ADD (0011), stall=1 two cycles with new id_* -> outputs unchanged; flush=1 with stall=1 -> next edge ex_valid=0, ex_ctrl=0, ex_alu_op=0000.
REQ-036 Immediate path: alu_src=1, imm=0xFFFFFFF0, rt forwarded from MEM/WB 0x55 -> ex_alu_b=0xFFFFFFF0, ex_store_data=0x55, fwd_b_sel=01.
